// File: rtl/logic_axi4_stream_upsizer_main.sv
// Purpose : packs N consecutive narrow AXI4-Stream beats (little-endian lanes) into one wide beat.
// Latency : 1 cycle from the completing rx beat to tx_tvalid_o; one rx beat per cycle sustained.
// Backpressure: rx_tready_o = !out_valid || tx_tready_i, except one stall cycle when a tid/tdest
//               change lands on a tlast beat (flush first, accept that beat next cycle).
// Ports: aclk/areset (sync, active-high); rx_* narrow slave stream; tx_* wide master stream.
module logic_axi4_stream_upsizer_main #(
    parameter int RX_TDATA_BYTES = 1,
    parameter int TX_TDATA_BYTES = 4,
    parameter int RX_TUSER_WIDTH = 1,
    parameter int TX_TUSER_WIDTH = RX_TUSER_WIDTH * (TX_TDATA_BYTES / RX_TDATA_BYTES),
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int USE_TLAST      = 1,
    parameter int USE_TKEEP      = 1,
    parameter int USE_TSTRB      = 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        rx_tvalid_i,
    output logic                        rx_tready_o,
    input  logic [RX_TDATA_BYTES*8-1:0] rx_tdata_i,
    input  logic [RX_TDATA_BYTES-1:0]   rx_tkeep_i,
    input  logic [RX_TDATA_BYTES-1:0]   rx_tstrb_i,
    input  logic [RX_TUSER_WIDTH-1:0]   rx_tuser_i,
    input  logic [TID_WIDTH-1:0]        rx_tid_i,
    input  logic [TDEST_WIDTH-1:0]      rx_tdest_i,
    input  logic                        rx_tlast_i,
    output logic                        tx_tvalid_o,
    input  logic                        tx_tready_i,
    output logic [TX_TDATA_BYTES*8-1:0] tx_tdata_o,
    output logic [TX_TDATA_BYTES-1:0]   tx_tkeep_o,
    output logic [TX_TDATA_BYTES-1:0]   tx_tstrb_o,
    output logic [TX_TUSER_WIDTH-1:0]   tx_tuser_o,
    output logic [TID_WIDTH-1:0]        tx_tid_o,
    output logic [TDEST_WIDTH-1:0]      tx_tdest_o,
    output logic                        tx_tlast_o
);

    localparam int N   = TX_TDATA_BYTES / RX_TDATA_BYTES;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int RDW = RX_TDATA_BYTES * 8;
    localparam int RKW = RX_TDATA_BYTES;
    localparam int RUW = RX_TUSER_WIDTH;
    localparam int TDW = TX_TDATA_BYTES * 8;
    localparam int TKW = TX_TDATA_BYTES;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    // Accumulator (top lane is never written; the completing beat goes straight to the output)
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [TDW-1:0]            acc_data_q, acc_data_d;
    logic [TKW-1:0]            acc_keep_q, acc_keep_d;
    logic [TKW-1:0]            acc_strb_q, acc_strb_d;
    logic [TX_TUSER_WIDTH-1:0] acc_user_q, acc_user_d;
    logic [TID_WIDTH-1:0]      hold_tid_q, hold_tid_d;
    logic [TDEST_WIDTH-1:0]    hold_tdest_q, hold_tdest_d;

    // Registered output stage
    logic                      out_valid_q, out_valid_d;
    logic [TDW-1:0]            out_data_q, out_data_d;
    logic [TKW-1:0]            out_keep_q, out_keep_d;
    logic [TKW-1:0]            out_strb_q, out_strb_d;
    logic [TX_TUSER_WIDTH-1:0] out_user_q, out_user_d;
    logic [TID_WIDTH-1:0]      out_tid_q, out_tid_d;
    logic [TDEST_WIDTH-1:0]    out_tdest_q, out_tdest_d;
    logic                      out_last_q, out_last_d;

    // Candidate output words: lanes below cnt (flush) and that plus the current beat (complete)
    logic [TDW-1:0]            flush_data, comp_data;
    logic [TKW-1:0]            flush_keep, comp_keep;
    logic [TKW-1:0]            flush_strb, comp_strb;
    logic [TX_TUSER_WIDTH-1:0] flush_user, comp_user;

    logic stage_rdy;
    logic last_beat;
    logic id_diff;
    logic flush_hold;
    logic flush_go;
    logic accept;

    assign stage_rdy  = !out_valid_q || tx_tready_i;
    assign last_beat  = (USE_TLAST != 0) && rx_tlast_i;
    assign id_diff    = (cnt_q != '0) && ((rx_tid_i != hold_tid_q) || (rx_tdest_i != hold_tdest_q));
    // A tlast beat with new ids would need two output words at once: flush now, take it next cycle.
    assign flush_hold = id_diff && last_beat;
    assign rx_tready_o = stage_rdy && !(rx_tvalid_i && flush_hold);
    assign accept     = rx_tvalid_i && rx_tready_o;
    assign flush_go   = rx_tvalid_i && stage_rdy && flush_hold;

    always_comb begin
        flush_data = '0;
        flush_keep = '0;
        flush_strb = '0;
        flush_user = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(cnt_q)) begin
                flush_data[k*RDW +: RDW] = acc_data_q[k*RDW +: RDW];
                flush_keep[k*RKW +: RKW] = acc_keep_q[k*RKW +: RKW];
                flush_strb[k*RKW +: RKW] = acc_strb_q[k*RKW +: RKW];
                flush_user[k*RUW +: RUW] = acc_user_q[k*RUW +: RUW];
            end
        end
        comp_data = flush_data;
        comp_keep = flush_keep;
        comp_strb = flush_strb;
        comp_user = flush_user;
        for (int k = 0; k < N; k++) begin
            if (k == int'(cnt_q)) begin
                comp_data[k*RDW +: RDW] = rx_tdata_i;
                comp_keep[k*RKW +: RKW] = rx_tkeep_i;
                comp_strb[k*RKW +: RKW] = rx_tstrb_i;
                comp_user[k*RUW +: RUW] = rx_tuser_i;
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_data_d   = acc_data_q;
        acc_keep_d   = acc_keep_q;
        acc_strb_d   = acc_strb_q;
        acc_user_d   = acc_user_q;
        hold_tid_d   = hold_tid_q;
        hold_tdest_d = hold_tdest_q;
        // Valid drops on a tx handshake unless a new word is loaded below
        out_valid_d  = out_valid_q && !tx_tready_i;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_strb_d   = out_strb_q;
        out_user_d   = out_user_q;
        out_tid_d    = out_tid_q;
        out_tdest_d  = out_tdest_q;
        out_last_d   = out_last_q;

        if (flush_go || (accept && id_diff)) begin
            // Emit the partial word under the old ids
            out_valid_d = 1'b1;
            out_data_d  = flush_data;
            out_keep_d  = flush_keep;
            out_strb_d  = flush_strb;
            out_user_d  = flush_user;
            out_tid_d   = hold_tid_q;
            out_tdest_d = hold_tdest_q;
            out_last_d  = 1'b0;
            cnt_d       = '0;
            if (accept) begin
                // Current beat starts a fresh accumulation in lane 0
                acc_data_d[RDW-1:0] = rx_tdata_i;
                acc_keep_d[RKW-1:0] = rx_tkeep_i;
                acc_strb_d[RKW-1:0] = rx_tstrb_i;
                acc_user_d[RUW-1:0] = rx_tuser_i;
                hold_tid_d          = rx_tid_i;
                hold_tdest_d        = rx_tdest_i;
                cnt_d               = CW'(1);
            end
        end else if (accept && ((cnt_q == CNT_MAX) || last_beat)) begin
            out_valid_d = 1'b1;
            out_data_d  = comp_data;
            out_keep_d  = comp_keep;
            out_strb_d  = comp_strb;
            out_user_d  = comp_user;
            out_tid_d   = (cnt_q == '0) ? rx_tid_i : hold_tid_q;
            out_tdest_d = (cnt_q == '0) ? rx_tdest_i : hold_tdest_q;
            out_last_d  = last_beat;
            cnt_d       = '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (k == int'(cnt_q)) begin
                    acc_data_d[k*RDW +: RDW] = rx_tdata_i;
                    acc_keep_d[k*RKW +: RKW] = rx_tkeep_i;
                    acc_strb_d[k*RKW +: RKW] = rx_tstrb_i;
                    acc_user_d[k*RUW +: RUW] = rx_tuser_i;
                end
            end
            if (cnt_q == '0) begin
                hold_tid_d   = rx_tid_i;
                hold_tdest_d = rx_tdest_i;
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q        <= '0;
            acc_data_q   <= '0;
            acc_keep_q   <= '0;
            acc_strb_q   <= '0;
            acc_user_q   <= '0;
            hold_tid_q   <= '0;
            hold_tdest_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_strb_q   <= '0;
            out_user_q   <= '0;
            out_tid_q    <= '0;
            out_tdest_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_data_q   <= acc_data_d;
            acc_keep_q   <= acc_keep_d;
            acc_strb_q   <= acc_strb_d;
            acc_user_q   <= acc_user_d;
            hold_tid_q   <= hold_tid_d;
            hold_tdest_q <= hold_tdest_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_strb_q   <= out_strb_d;
            out_user_q   <= out_user_d;
            out_tid_q    <= out_tid_d;
            out_tdest_q  <= out_tdest_d;
            out_last_q   <= out_last_d;
        end
    end

    assign tx_tvalid_o = out_valid_q;
    assign tx_tdata_o  = out_data_q;
    assign tx_tkeep_o  = (USE_TKEEP != 0) ? out_keep_q : '1;
    assign tx_tstrb_o  = (USE_TSTRB != 0) ? out_strb_q : '1;
    assign tx_tuser_o  = out_user_q;
    assign tx_tid_o    = out_tid_q;
    assign tx_tdest_o  = out_tdest_q;
    assign tx_tlast_o  = out_last_q;

endmodule

// File: tb/tb_logic_axi4_stream_upsizer_main.sv
// Purpose : self-checking bench for the stream upsizer (N=4 byte-to-word and N=1 pass-through).
// Latency : checks sampled 1 time unit after each falling edge, inputs driven on the falling edge.
// Backpressure: exercises tx stalls, id-change flushes and random tready with a packing model.
module tb_logic_axi4_stream_upsizer_main;

    logic        clk;
    logic        areset;
    // N = 4 instance
    logic        rx_tvalid, rx_tready, rx_tlast;
    logic [7:0]  rx_tdata;
    logic [0:0]  rx_tkeep, rx_tstrb, rx_tuser, rx_tdest;
    logic [1:0]  rx_tid;
    logic        tx_tvalid, tx_tready, tx_tlast;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tkeep, tx_tstrb, tx_tuser;
    logic [1:0]  tx_tid;
    logic [0:0]  tx_tdest;
    // N = 1 instance
    logic        n_rx_tvalid, n_rx_tready, n_rx_tlast;
    logic [31:0] n_rx_tdata;
    logic [3:0]  n_rx_tkeep, n_rx_tstrb;
    logic [0:0]  n_rx_tuser, n_rx_tid, n_rx_tdest;
    logic        n_tx_tvalid, n_tx_tready, n_tx_tlast;
    logic [31:0] n_tx_tdata;
    logic [3:0]  n_tx_tkeep, n_tx_tstrb;
    logic [0:0]  n_tx_tuser, n_tx_tid, n_tx_tdest;

    int n_tests = 0;
    int n_fail  = 0;

    logic_axi4_stream_upsizer_main #(
        .RX_TDATA_BYTES(1), .TX_TDATA_BYTES(4), .RX_TUSER_WIDTH(1), .TX_TUSER_WIDTH(4),
        .TDEST_WIDTH(1), .TID_WIDTH(2), .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)
    ) u_dut (
        .aclk(clk), .areset(areset),
        .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready), .rx_tdata_i(rx_tdata),
        .rx_tkeep_i(rx_tkeep), .rx_tstrb_i(rx_tstrb), .rx_tuser_i(rx_tuser),
        .rx_tid_i(rx_tid), .rx_tdest_i(rx_tdest), .rx_tlast_i(rx_tlast),
        .tx_tvalid_o(tx_tvalid), .tx_tready_i(tx_tready), .tx_tdata_o(tx_tdata),
        .tx_tkeep_o(tx_tkeep), .tx_tstrb_o(tx_tstrb), .tx_tuser_o(tx_tuser),
        .tx_tid_o(tx_tid), .tx_tdest_o(tx_tdest), .tx_tlast_o(tx_tlast)
    );

    logic_axi4_stream_upsizer_main #(
        .RX_TDATA_BYTES(4), .TX_TDATA_BYTES(4), .RX_TUSER_WIDTH(1), .TX_TUSER_WIDTH(1),
        .TDEST_WIDTH(1), .TID_WIDTH(1), .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)
    ) u_dut1 (
        .aclk(clk), .areset(areset),
        .rx_tvalid_i(n_rx_tvalid), .rx_tready_o(n_rx_tready), .rx_tdata_i(n_rx_tdata),
        .rx_tkeep_i(n_rx_tkeep), .rx_tstrb_i(n_rx_tstrb), .rx_tuser_i(n_rx_tuser),
        .rx_tid_i(n_rx_tid), .rx_tdest_i(n_rx_tdest), .rx_tlast_i(n_rx_tlast),
        .tx_tvalid_o(n_tx_tvalid), .tx_tready_i(n_tx_tready), .tx_tdata_o(n_tx_tdata),
        .tx_tkeep_o(n_tx_tkeep), .tx_tstrb_o(n_tx_tstrb), .tx_tuser_o(n_tx_tuser),
        .tx_tid_o(n_tx_tid), .tx_tdest_o(n_tx_tdest), .tx_tlast_o(n_tx_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] watchdog expired before the end of the test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic [1:0]  tid;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_dat;
        logic [3:0]  e_keep;
        logic        e_last;
        logic [1:0]  e_tid;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic vb(input logic [7:0] dat, input logic last, input logic [1:0] tid, input logic e_rdy,
                      input logic e_vld, input logic [31:0] e_dat, input logic [3:0] e_keep,
                      input logic e_last, input logic [1:0] e_tid);
        vq.push_back('{1'b1, dat, last, tid, e_rdy, e_vld, e_dat, e_keep, e_last, e_tid});
    endtask

    task automatic vi(input logic e_vld, input logic [31:0] e_dat, input logic [3:0] e_keep,
                      input logic e_last, input logic [1:0] e_tid);
        vq.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, e_vld, e_dat, e_keep, e_last, e_tid});
    endtask

    // One cycle on the N=4 instance: drive on the falling edge, settle, then sample.
    task automatic cyc(input logic vld, input logic [7:0] dat, input logic last, input logic rdy);
        @(negedge clk);
        rx_tvalid = vld;
        rx_tdata  = dat;
        rx_tlast  = last;
        tx_tready = rdy;
        #1;
    endtask

    logic [40:0] expq[$];
    logic [40:0] exp_w;
    logic [39:0] snap;
    logic        prev_stall;
    logic        pending;
    logic [7:0]  cur_dat;
    logic        cur_last;
    logic [31:0] m_dat;
    logic [3:0]  m_keep;
    int          m_cnt;
    int          beat_idx;
    int          cycles;
    logic [31:0] n_beats [3];

    initial begin
        areset = 1'b1;
        rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = 1'b1; rx_tstrb = 1'b1; rx_tuser = 1'b1;
        rx_tid = '0; rx_tdest = '0; rx_tlast = 1'b0; tx_tready = 1'b1;
        n_rx_tvalid = 1'b0; n_rx_tdata = '0; n_rx_tkeep = 4'hF; n_rx_tstrb = 4'hF; n_rx_tuser = 1'b1;
        n_rx_tid = '0; n_rx_tdest = '0; n_rx_tlast = 1'b0; n_tx_tready = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_tx_tvalid", tx_tvalid, 0);
        chk("reset_tx_tdata", tx_tdata, 0);
        chk("reset_tx_tkeep", tx_tkeep, 0);
        chk("reset_n1_tx_tvalid", n_tx_tvalid, 0);
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("reset_rx_tready", rx_tready, 1);

        // ---------------- directed vector table (tx_tready = 1) ----------------
        // full words, tlast on beat 8
        vb(8'h11, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'h22, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'h33, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'h44, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'h55, 0, 0, 1, 1, 32'h44332211, 4'hF, 0, 0);
        vb(8'h66, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'h77, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'h88, 1, 0, 1, 0, 0, 0, 0, 0);
        vi(1, 32'h88776655, 4'hF, 1, 0);
        vi(0, 0, 0, 0, 0);
        // short packet, zero padded
        vb(8'hA1, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'hA2, 0, 0, 1, 0, 0, 0, 0, 0);
        vb(8'hA3, 1, 0, 1, 0, 0, 0, 0, 0);
        vi(1, 32'h00A3A2A1, 4'h7, 1, 0);
        vi(0, 0, 0, 0, 0);
        // tid change mid-word splits
        vb(8'h01, 0, 1, 1, 0, 0, 0, 0, 0);
        vb(8'h02, 0, 1, 1, 0, 0, 0, 0, 0);
        vb(8'h03, 0, 2, 1, 0, 0, 0, 0, 0);
        vb(8'h04, 0, 2, 1, 1, 32'h00000201, 4'h3, 0, 1);
        vb(8'h05, 0, 2, 1, 0, 0, 0, 0, 0);
        vb(8'h06, 0, 2, 1, 0, 0, 0, 0, 0);
        vi(1, 32'h06050403, 4'hF, 0, 2);
        vi(0, 0, 0, 0, 0);
        // tid change on a tlast beat: one-cycle stall, flush, then complete
        vb(8'h07, 0, 1, 1, 0, 0, 0, 0, 0);
        vb(8'h08, 1, 2, 0, 0, 0, 0, 0, 0);
        vb(8'h08, 1, 2, 1, 1, 32'h00000007, 4'h1, 0, 1);
        vi(1, 32'h00000008, 4'h1, 1, 2);
        vi(0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rx_tvalid = vq[i].vld;
            rx_tdata  = vq[i].dat;
            rx_tlast  = vq[i].last;
            rx_tid    = vq[i].tid;
            tx_tready = 1'b1;
            #1;
            chk($sformatf("vec%0d_rx_tready", i), rx_tready, vq[i].e_rdy);
            chk($sformatf("vec%0d_tx_tvalid", i), tx_tvalid, vq[i].e_vld);
            if (vq[i].e_vld) begin
                chk($sformatf("vec%0d_tdata", i), tx_tdata, vq[i].e_dat);
                chk($sformatf("vec%0d_tkeep", i), tx_tkeep, vq[i].e_keep);
                chk($sformatf("vec%0d_tstrb", i), tx_tstrb, vq[i].e_keep);
                chk($sformatf("vec%0d_tuser", i), tx_tuser, vq[i].e_keep);
                chk($sformatf("vec%0d_tlast", i), tx_tlast, vq[i].e_last);
                chk($sformatf("vec%0d_tid", i), tx_tid, vq[i].e_tid);
            end
        end
        rx_tid = '0;

        // ---------------- tx stall for 10 cycles ----------------
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'hB1 + 8'(i), 0, 0);
            chk($sformatf("stall_fill%0d_rx_tready", i), rx_tready, 1);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'hB5, 0, 0);
            chk($sformatf("stall%0d_tx_tvalid", i), tx_tvalid, 1);
            chk($sformatf("stall%0d_tdata", i), tx_tdata, 32'hB4B3B2B1);
            chk($sformatf("stall%0d_tkeep", i), tx_tkeep, 4'hF);
            chk($sformatf("stall%0d_rx_tready", i), rx_tready, 0);
        end
        cyc(1, 8'hB5, 0, 1);
        chk("stall_release_rx_tready", rx_tready, 1);
        chk("stall_release_tdata", tx_tdata, 32'hB4B3B2B1);
        cyc(1, 8'hB6, 0, 1);
        chk("stall_b6_tx_tvalid", tx_tvalid, 0);
        cyc(1, 8'hB7, 0, 1);
        cyc(1, 8'hB8, 1, 1);
        cyc(0, 8'h00, 0, 1);
        chk("stall_w2_tx_tvalid", tx_tvalid, 1);
        chk("stall_w2_tdata", tx_tdata, 32'hB8B7B6B5);
        chk("stall_w2_tlast", tx_tlast, 1);
        cyc(0, 8'h00, 0, 1);
        chk("stall_w2_drop", tx_tvalid, 0);

        // ---------------- reset mid-packet ----------------
        cyc(1, 8'hC1, 0, 1);
        cyc(1, 8'hC2, 0, 1);
        @(negedge clk);
        rx_tvalid = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("rst_mid_tx_tvalid", tx_tvalid, 0);
        chk("rst_mid_rx_tready", rx_tready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'hD1 + 8'(i), 0, 1);
            chk($sformatf("rst_mid_d%0d_tx_tvalid", i), tx_tvalid, 0);
        end
        cyc(0, 8'h00, 0, 1);
        chk("rst_mid_word_vld", tx_tvalid, 1);
        chk("rst_mid_word_tdata", tx_tdata, 32'hD4D3D2D1);
        chk("rst_mid_word_tkeep", tx_tkeep, 4'hF);
        cyc(0, 8'h00, 0, 1);
        chk("rst_mid_drop", tx_tvalid, 0);

        // ---------------- random tready / tvalid, packing scoreboard ----------------
        m_dat = '0; m_keep = '0; m_cnt = 0; beat_idx = 0; cycles = 0;
        pending = 1'b0; prev_stall = 1'b0; snap = '0; cur_dat = '0; cur_last = 1'b0;
        while ((beat_idx < 1000 || expq.size() != 0 || tx_tvalid) && cycles < 20000) begin
            if (!pending && beat_idx < 1000 && $urandom_range(3) != 0) begin
                cur_dat  = 8'($urandom_range(255));
                cur_last = (beat_idx == 999) || ($urandom_range(7) == 0);
                pending  = 1'b1;
            end
            cyc(pending, cur_dat, cur_last, (beat_idx >= 1000) ? 1'b1 : 1'($urandom_range(1)));
            cycles++;
            if (prev_stall)
                chk($sformatf("rand_stable_c%0d", cycles), {tx_tvalid, tx_tlast, tx_tid, tx_tkeep, tx_tdata}, snap);
            if (tx_tvalid && tx_tready) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_extra_word: got 0x%0h expected no word", tx_tdata);
                end else begin
                    exp_w = expq.pop_front();
                    chk($sformatf("rand_word_c%0d", cycles), {tx_tlast, tx_tuser, tx_tkeep, tx_tdata}, exp_w);
                end
            end
            if (rx_tvalid && rx_tready) begin
                m_dat[m_cnt*8 +: 8] = cur_dat;
                m_keep[m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == 4 || cur_last) begin
                    expq.push_back({cur_last, m_keep, m_keep, m_dat});
                    m_dat = '0; m_keep = '0; m_cnt = 0;
                end
                pending = 1'b0;
                beat_idx++;
            end
            prev_stall = tx_tvalid && !tx_tready;
            snap = {tx_tvalid, tx_tlast, tx_tid, tx_tkeep, tx_tdata};
        end
        chk("rand_beats_accepted", beat_idx, 1000);
        chk("rand_words_left", expq.size(), 0);
        cyc(0, 8'h00, 0, 1);

        // ---------------- N = 1 pass-through at full rate ----------------
        n_beats[0] = 32'hDEADBEEF;
        n_beats[1] = 32'h01234567;
        n_beats[2] = 32'h89ABCDEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_rx_tvalid = (i < 3);
            n_rx_tdata  = (i < 3) ? n_beats[i] : 32'h0;
            n_rx_tlast  = (i == 2);
            #1;
            chk($sformatf("n1_c%0d_rx_tready", i), n_rx_tready, 1);
            chk($sformatf("n1_c%0d_tx_tvalid", i), n_tx_tvalid, (i > 0));
            if (i > 0) begin
                chk($sformatf("n1_c%0d_tdata", i), n_tx_tdata, n_beats[i-1]);
                chk($sformatf("n1_c%0d_tkeep", i), n_tx_tkeep, 4'hF);
                chk($sformatf("n1_c%0d_tlast", i), n_tx_tlast, (i == 3));
            end
        end
        @(negedge clk);
        #1;
        chk("n1_drop", n_tx_tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
